mips_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the MIPS datapath: next-generation successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Stalls on a ready/request memory handshake; traps illegal opcodes and memory timeouts.
- Sits between the IR/ALU-flag outputs of the datapath and every datapath enable/mux select.

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mips_alu_dec.sv | 29 ++
 rtl/mips_mc_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcode/funct constants, ALU codes, control encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;
  localparam logic [4:0] ALU_CMP  = 5'd12;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_BR  = 2'd1;
  localparam logic [1:0] PC_SRC_JMP = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - R-type funct to ALU operation decoder
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] alu_code,
  output logic       illegal
);

  always_comb begin
    alu_code = ALU_NOP;
    illegal  = 1'b0;
    case (funct)
      FN_ADD:  alu_code = ALU_ADD;
      FN_SUB:  alu_code = ALU_SUB;
      FN_AND:  alu_code = ALU_AND;
      FN_OR:   alu_code = ALU_OR;
      FN_XOR:  alu_code = ALU_XOR;
      FN_NOR:  alu_code = ALU_NOR;
      FN_SLT:  alu_code = ALU_SLT;
      FN_SLTU: alu_code = ALU_SLTU;
      FN_SLL:  alu_code = ALU_SLL;
      FN_SRL:  alu_code = ALU_SRL;
      FN_SRA:  alu_code = ALU_SRA;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM with memory handshake and traps
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int ALUCTR_W     = 5,
  parameter int MEM_TIMEOUT  = 16,
  parameter int EN_BNE       = 1,
  parameter int EN_ADDIU_ORI = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_rdy,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_wr,
  output logic                pc_wr,
  output logic [1:0]          pc_src,
  output logic                reg_wr,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                ext_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                retire,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       r_code, alu_code;
  logic             r_illegal;

  mips_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_code (r_code),
    .illegal  (r_illegal)
  );

  logic is_r, is_j, is_beq, is_bne, is_addi, is_addiu, is_ori, is_lw, is_sw;
  logic illegal, mem_wait, timeout_hit, br_take;

  assign is_r     = (opcode == OP_RTYPE);
  assign is_j     = (opcode == OP_J);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (EN_BNE != 0) && (opcode == OP_BNE);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_addiu = (EN_ADDIU_ORI != 0) && (opcode == OP_ADDIU);
  assign is_ori   = (EN_ADDIU_ORI != 0) && (opcode == OP_ORI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);

  assign illegal = !(is_r || is_j || is_beq || is_bne || is_addi || is_addiu ||
                     is_ori || is_lw || is_sw) || (is_r && r_illegal);

  // Timeout fires on the wait cycle that would push the count to MEM_TIMEOUT;
  // a mem_rdy in that same cycle still completes normally.
  assign mem_wait    = ((state_q == S_IF) || (state_q == S_MEM)) && !mem_rdy;
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait &&
                       (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign br_take     = (is_beq && zero) || (is_bne && !zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IF: begin
        if (mem_rdy) state_d = S_ID;
        else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_ID: begin
        if (illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (is_j) state_d = S_IF;
        else state_d = S_EX;
      end
      S_EX: begin
        if (is_lw || is_sw) state_d = S_MEM;
        else if (is_beq || is_bne) state_d = S_IF;
        else state_d = S_WB;
      end
      S_MEM: begin
        if (mem_rdy) state_d = is_sw ? S_IF : S_WB;
        else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_d = S_IF;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
    // Any state change clears the counter, which covers every entry into IF/MEM.
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + 1'b1;
    else                    cnt_d = cnt_q;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PC_SRC_PC4;
    reg_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_code   = ALU_NOP;
    retire     = 1'b0;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;
    // Every strobe is held low while reset is asserted, even though state reads IF.
    if (rst_n) begin
      trap_cause = cause_q;
      case (state_q)
        S_IF: begin
          mem_req   = 1'b1;
          alu_src_b = SRCB_FOUR;
          alu_code  = ALU_ADD;
          ir_wr     = mem_rdy;
          pc_wr     = mem_rdy;
        end
        S_ID: begin
          alu_src_b = SRCB_IMM_SH;
          ext_op    = 1'b1;
          alu_code  = ALU_ADD;
          if (!illegal && is_j) begin
            pc_wr  = 1'b1;
            pc_src = PC_SRC_JMP;
            retire = 1'b1;
          end
        end
        S_EX: begin
          alu_src_a = 1'b1;
          if (is_r) begin
            alu_src_b = SRCB_RT;
            alu_code  = r_code;
          end else if (is_beq || is_bne) begin
            alu_src_b = SRCB_RT;
            alu_code  = ALU_CMP;
            pc_wr     = br_take;
            pc_src    = br_take ? PC_SRC_BR : PC_SRC_PC4;
            retire    = 1'b1;
          end else if (is_ori) begin
            alu_src_b = SRCB_IMM;
            alu_code  = ALU_OR;
          end else begin
            alu_src_b = SRCB_IMM;
            ext_op    = 1'b1;
            alu_code  = ALU_ADD;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
          retire  = mem_rdy && is_sw;
        end
        S_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = !is_r;
          mem_to_reg = is_lw;
          retire     = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_ctr = ALUCTR_W'(alu_code);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - directed self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_rdy;
  logic       mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, reg_dst, mem_to_reg;
  logic       ext_op, alu_src_a, retire, trap;
  logic [1:0] pc_src, alu_src_b, trap_cause;
  logic [4:0] alu_ctr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(
    .ALUCTR_W(5), .MEM_TIMEOUT(4), .EN_BNE(0), .EN_ADDIU_ORI(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .ext_op(ext_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctr(alu_ctr),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
  );

  logic [7:0] strobes;
  assign strobes = {mem_req, mem_we, iord, ir_wr, pc_wr, reg_wr, mem_to_reg, retire};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs are then driven and
  // outputs sampled 1 ns later, well clear of either edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic rdy, input logic z);
    mem_rdy = rdy;
    zero    = z;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [5:0] fn_tab [4] = '{6'b100000, 6'b100111, 6'b101011, 6'b000011};
  logic [4:0] code_tab [4] = '{5'd1, 5'd6, 5'd8, 5'd11};

  initial begin
    rst_n = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; mem_rdy = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_strobes", strobes, 0);
    check("rst_trap", trap, 0);
    check("rst_cause", trap_cause, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // R-type table: add first, then nor/sltu/sra through the same 4-cycle path
    for (int i = 0; i < 4; i++) begin
      opcode = 6'b000000; funct = fn_tab[i];
      settle(1, 0);
      check("r_if_req", mem_req, 1);  check("r_if_iord", iord, 0);
      check("r_if_irwr", ir_wr, 1);   check("r_if_pcwr", pc_wr, 1);
      check("r_if_srcb", alu_src_b, 1); check("r_if_alu", alu_ctr, 1);
      tick(); settle(0, 0);
      check("r_id_srcb", alu_src_b, 3); check("r_id_ext", ext_op, 1);
      check("r_id_strobes", strobes, 0);
      tick(); settle(0, 0);
      check("r_ex_alu", alu_ctr, code_tab[i]);
      check("r_ex_srca", alu_src_a, 1); check("r_ex_srcb", alu_src_b, 0);
      check("r_ex_regwr", reg_wr, 0);
      tick(); settle(0, 0);
      check("r_wb_regwr", reg_wr, 1); check("r_wb_dst", reg_dst, 0);
      check("r_wb_retire", retire, 1); check("r_wb_pcwr", pc_wr, 0);
      tick();
    end

    // lw with three wait cycles in IF and in MEM: 11 cycles total
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      settle(0, 0);
      check("lw_if_req", mem_req, 1); check("lw_if_irwr", ir_wr, 0);
      tick();
    end
    settle(1, 0); check("lw_if_irwr_rdy", ir_wr, 1);
    tick(); settle(0, 0); tick();
    settle(0, 0);
    check("lw_ex_srcb", alu_src_b, 2); check("lw_ex_ext", ext_op, 1);
    check("lw_ex_alu", alu_ctr, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      settle(0, 0);
      check("lw_mem_req", mem_req, 1); check("lw_mem_iord", iord, 1);
      check("lw_mem_we", mem_we, 0);   check("lw_mem_trap", trap, 0);
      tick();
    end
    settle(1, 0);
    check("lw_mem_req_rdy", mem_req, 1); check("lw_mem_retire", retire, 0);
    tick(); settle(0, 0);
    check("lw_wb_regwr", reg_wr, 1); check("lw_wb_m2r", mem_to_reg, 1);
    check("lw_wb_dst", reg_dst, 1);  check("lw_wb_retire", retire, 1);
    tick(); settle(0, 0);
    check("lw_next_if", mem_req & ~iord, 1); check("lw_no_trap", trap, 0);

    // beq taken then not taken, both retiring in EX
    opcode = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      settle(1, 0); tick(); settle(0, 0); tick();
      settle(0, (i == 0));
      check("beq_alu", alu_ctr, 12);
      check("beq_pcwr", pc_wr, (i == 0));
      check("beq_pcsrc", pc_src, (i == 0) ? 1 : 0);
      check("beq_retire", retire, 1);
      check("beq_regwr", reg_wr, 0);
      tick();
    end

    // j retires in ID
    opcode = 6'b000010;
    settle(1, 0); tick(); settle(0, 0);
    check("j_pcwr", pc_wr, 1); check("j_pcsrc", pc_src, 2);
    check("j_retire", retire, 1);
    tick(); settle(0, 0);
    check("j_next_if", mem_req, 1);

    // ori zero-extends and uses the or code
    opcode = 6'b001101;
    settle(1, 0); tick(); settle(0, 0); tick(); settle(0, 0);
    check("ori_ext", ext_op, 0); check("ori_alu", alu_ctr, 4);
    check("ori_srcb", alu_src_b, 2);
    tick(); settle(0, 0);
    check("ori_wb_dst", reg_dst, 1); check("ori_wb_regwr", reg_wr, 1);
    tick();

    // addi interrupted by reset during WB
    opcode = 6'b001000;
    settle(1, 0); tick(); settle(0, 0); tick(); settle(0, 0);
    check("addi_ex_srcb", alu_src_b, 2); check("addi_ex_alu", alu_ctr, 1);
    tick(); settle(0, 0);
    check("addi_wb_regwr", reg_wr, 1); check("addi_wb_dst", reg_dst, 1);
    rst_n = 1'b0;
    #1;
    check("addi_rst_regwr", reg_wr, 0); check("addi_rst_strobes", strobes, 0);
    tick();
    rst_n = 1'b1;
    tick(); settle(0, 0);
    check("addi_rel_req", mem_req, 1); check("addi_rel_iord", iord, 0);
    check("addi_rel_trap", trap, 0);   check("addi_rel_regwr", reg_wr, 0);

    // sw with memory never ready in MEM: trap exactly 4 cycles after entry
    opcode = 6'b101011;
    settle(1, 0); tick(); settle(0, 0); tick(); settle(0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      settle(0, 0);
      check("sw_mem_req", mem_req, 1); check("sw_mem_we", mem_we, 1);
      check("sw_mem_trap", trap, 0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      settle(i == 1, 0);
      check("sw_trap", trap, 1); check("sw_cause", trap_cause, 2);
      check("sw_trap_req", mem_req, 0); check("sw_trap_we", mem_we, 0);
      tick();
    end
    do_reset();

    // bne is illegal with EN_BNE=0: trap from ID, then ten silent cycles
    opcode = 6'b000101;
    settle(1, 0); tick(); settle(1, 0);
    check("bne_id_pcwr", pc_wr, 0); check("bne_id_retire", retire, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      settle(1, 1);
      check("bne_trap_strobes", strobes, 0);
      check("bne_trap", trap, 1); check("bne_cause", trap_cause, 1);
      tick();
    end
    do_reset();
    settle(0, 0);
    check("post_rst_cause", trap_cause, 0); check("post_rst_trap", trap, 0);

    // undefined R-type funct traps with cause 1
    opcode = 6'b000000; funct = 6'b000001;
    settle(1, 0); tick(); settle(0, 0); tick(); settle(0, 0);
    check("badfn_trap", trap, 1); check("badfn_cause", trap_cause, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
